// File: rtl/play_pkg.sv
// Shared encodings and constants for the playlist controller and its elapsed-time timer.
package play_pkg;

    typedef enum logic [1:0] {
        MODE_SEQ        = 2'd0,
        MODE_LOOP       = 2'd1,
        MODE_REPEAT_ONE = 2'd2,
        MODE_SHUFFLE    = 2'd3
    } play_mode_e;

    localparam logic [15:0] LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;
    localparam logic [7:0]  MINUTE_MAX = 8'd99;
    localparam logic [7:0]  SECOND_MAX = 8'd59;

    // Right-shifting Galois form: feedback taken from bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/play_timer.sv
// Elapsed playback time: prescaler to 1 Hz tick, then mm:ss counters saturating at 99:59.
// Latency: registered, updates one cycle after run/clear; no backpressure (free-running while run).
module play_timer
    import play_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       clear,
    output logic [7:0] o_minute,
    output logic [7:0] o_second
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    second_q, second_d;
    logic [7:0]    minute_q, minute_d;
    logic          tick;

    always_comb begin
        presc_d  = presc_q;
        second_d = second_q;
        minute_d = minute_q;
        tick     = 1'b0;
        if (clear) begin
            presc_d  = '0;
            second_d = '0;
            minute_d = '0;
        end else if (run) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                tick    = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        // At 99:59 the clock simply freezes.
        if (tick) begin
            if (second_q == SECOND_MAX) begin
                if (minute_q != MINUTE_MAX) begin
                    second_d = '0;
                    minute_d = minute_q + 8'd1;
                end
            end else begin
                second_d = second_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q  <= '0;
            second_q <= '0;
            minute_q <= '0;
        end else begin
            presc_q  <= presc_d;
            second_q <= second_d;
            minute_q <= minute_d;
        end
    end

    assign o_minute = minute_q;
    assign o_second = second_q;

endmodule

// File: rtl/play_ctrl.sv
// Music player control: song index per play mode, pause/stop, volume word and LED bar, elapsed time.
// Latency: all outputs registered, one cycle after a request pulse; no backpressure, pulses never stall.
module play_ctrl
    import play_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int SONG_NUM   = 4,
    parameter int VOL_LEVELS = 8,
    parameter int ATT_STEP   = 16,
    parameter int LED_W      = 8,
    localparam int SW        = (SONG_NUM > 2) ? $clog2(SONG_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_next,
    input  logic             i_pre,
    input  logic             i_finish_song,
    input  logic             i_pause_tgl,
    input  logic             i_vol_plus,
    input  logic             i_vol_dec,
    input  logic [1:0]       i_mode,
    output logic [SW-1:0]    o_song_select,
    output logic             o_song_change,
    output logic             o_pause,
    output logic             o_stopped,
    output logic [3:0]       o_vol_level,
    output logic [15:0]      o_vol,
    output logic [LED_W-1:0] o_vol_led,
    output logic [7:0]       o_minute,
    output logic [7:0]       o_second
);

    localparam logic [SW-1:0] LAST_IDX = SW'(SONG_NUM - 1);
    localparam logic [3:0]    VOL_MAX  = 4'(VOL_LEVELS);
    localparam logic [3:0]    VOL_RST  = 4'(VOL_LEVELS / 2);

    function automatic logic [SW-1:0] idx_inc(input logic [SW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + SW'(1);
    endfunction

    function automatic logic [SW-1:0] idx_dec(input logic [SW-1:0] i);
        return (i == '0) ? LAST_IDX : i - SW'(1);
    endfunction

    function automatic logic [15:0] vol_word(input logic [3:0] lvl);
        int a;
        a = (VOL_LEVELS - int'(lvl)) * ATT_STEP;
        if (a > 254) a = 254;
        return {8'(a), 8'(a)};
    endfunction

    function automatic logic [LED_W-1:0] led_bar(input logic [3:0] lvl);
        logic [LED_W-1:0] b;
        int thr;
        b   = '0;
        thr = int'(lvl) * LED_W / VOL_LEVELS;
        for (int k = 0; k < LED_W; k++) b[k] = (k < thr);
        return b;
    endfunction

    logic [SW-1:0]    sel_q, sel_d;
    logic             chg_q, chg_d;
    logic             pause_q, pause_d;
    logic             stopped_q, stopped_d;
    logic [3:0]       lvl_q, lvl_d;
    logic [15:0]      vol_q, vol_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [15:0]      lfsr_q, lfsr_d;

    play_mode_e    mode;
    logic          manual;
    logic [SW-1:0] cand;
    logic [SW-1:0] shuffle_pick;

    assign mode   = play_mode_e'(i_mode);
    assign manual = i_next ^ i_pre;
    assign cand   = SW'(lfsr_q % 16'(SONG_NUM));
    // Never replay the song that just ended.
    assign shuffle_pick = (cand == sel_q) ? idx_inc(cand) : cand;

    always_comb begin
        sel_d     = sel_q;
        chg_d     = 1'b0;
        pause_d   = pause_q;
        stopped_d = stopped_q;
        lvl_d     = lvl_q;
        lfsr_d    = lfsr_step(lfsr_q);

        if (manual) begin
            if (i_next) sel_d = (mode == MODE_SHUFFLE) ? shuffle_pick : idx_inc(sel_q);
            else        sel_d = idx_dec(sel_q);
            chg_d     = 1'b1;
            pause_d   = 1'b0;
            stopped_d = 1'b0;
        end else if (i_pause_tgl && stopped_q) begin
            sel_d     = '0;
            chg_d     = 1'b1;
            pause_d   = 1'b0;
            stopped_d = 1'b0;
        end else begin
            if (i_finish_song) begin
                unique case (mode)
                    MODE_SEQ: begin
                        if (sel_q == LAST_IDX) begin
                            stopped_d = 1'b1;
                        end else begin
                            sel_d = idx_inc(sel_q);
                            chg_d = 1'b1;
                        end
                    end
                    MODE_LOOP: begin
                        sel_d = idx_inc(sel_q);
                        chg_d = 1'b1;
                    end
                    MODE_REPEAT_ONE: chg_d = 1'b1;
                    MODE_SHUFFLE: begin
                        sel_d = shuffle_pick;
                        chg_d = 1'b1;
                    end
                    default: ;
                endcase
                if (chg_d) stopped_d = 1'b0;
            end
            if (i_pause_tgl) pause_d = !pause_q;
        end

        if (i_vol_plus && !i_vol_dec && (lvl_q != VOL_MAX)) lvl_d = lvl_q + 4'd1;
        if (i_vol_dec && !i_vol_plus && (lvl_q != 4'd0))    lvl_d = lvl_q - 4'd1;

        vol_d = vol_word(lvl_d);
        led_d = led_bar(lvl_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q     <= '0;
            chg_q     <= 1'b0;
            pause_q   <= 1'b0;
            stopped_q <= 1'b0;
            lvl_q     <= VOL_RST;
            vol_q     <= vol_word(VOL_RST);
            led_q     <= led_bar(VOL_RST);
            lfsr_q    <= LFSR_SEED;
        end else begin
            sel_q     <= sel_d;
            chg_q     <= chg_d;
            pause_q   <= pause_d;
            stopped_q <= stopped_d;
            lvl_q     <= lvl_d;
            vol_q     <= vol_d;
            led_q     <= led_d;
            lfsr_q    <= lfsr_d;
        end
    end

    // Timer follows the next-state values so clear and restart line up with the visible pulse.
    play_timer #(
        .CLK_HZ (CLK_HZ)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (!pause_d && !stopped_d),
        .clear    (chg_d),
        .o_minute (o_minute),
        .o_second (o_second)
    );

    assign o_song_select = sel_q;
    assign o_song_change = chg_q;
    assign o_pause       = pause_q;
    assign o_stopped     = stopped_q;
    assign o_vol_level   = lvl_q;
    assign o_vol         = vol_q;
    assign o_vol_led     = led_q;

endmodule
